// File: rtl/seg_scroll_ctrl.sv
// Scroll controller for the 8-digit seven-segment display: holds a 16-entry hex
// message and rewrites all 8 digits per frame, sliding a circular window between frames.
module seg_scroll_ctrl #(
   parameter int TICK_DIV = 50_000_000,
   parameter int CW       = 26
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       load_en,
   input  logic [3:0] load_addr,
   input  logic [3:0] load_data,
   input  logic       start,
   input  logic       stop,
   input  logic       dir,
   output logic       wr,
   output logic [2:0] sel,
   output logic [3:0] num,
   output logic       busy,
   output logic       frame_done,
   output logic [3:0] offset
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;

   localparam logic [CW-1:0] TICK_LOAD = CW'(TICK_DIV);
   localparam logic [CW-1:0] TICK_LAST = CW'(1);

   state_t          state_q, state_d;
   logic [3:0]      buf_q [16];
   logic [3:0]      buf_d [16];
   logic            wr_q, wr_d;
   logic [2:0]      sel_q, sel_d;
   logic [3:0]      num_q, num_d;
   logic            frame_done_q, frame_done_d;
   logic [3:0]      offset_q, offset_d;
   logic [CW-1:0]   tick_q, tick_d;
   logic            pend_q, pend_d;
   logic [2:0]      sel_nxt;
   logic [3:0]      rd_idx;

   // Reads use buf_q, so a frame digit fetched on the same edge as a write sees the old value.
   always_comb begin
      buf_d = buf_q;
      if (load_en) begin
         buf_d[load_addr] = load_data;
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_d         = 1'b0;
      sel_d        = sel_q;
      num_d        = num_q;
      frame_done_d = 1'b0;
      offset_d     = offset_q;
      tick_d       = tick_q;
      pend_d       = pend_q;
      sel_nxt      = sel_q + 3'd1;
      rd_idx       = offset_q + {1'b0, sel_nxt};

      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               state_d = S_WRITE;
               wr_d    = 1'b1;
               sel_d   = 3'd0;
               num_d   = buf_q[offset_q];
            end
         end
         S_WRITE: begin
            pend_d = pend_q | stop;
            if (sel_q == 3'd7) begin
               state_d      = S_WAIT;
               frame_done_d = 1'b1;
               tick_d       = TICK_LOAD;
            end else begin
               wr_d  = 1'b1;
               sel_d = sel_nxt;
               num_d = buf_q[rd_idx];
            end
         end
         S_WAIT: begin
            pend_d = pend_q | stop;
            if (tick_q == TICK_LAST) begin
               // A stop seen on the final wait cycle still ends scrolling here.
               if (pend_d) begin
                  state_d = S_IDLE;
                  pend_d  = 1'b0;
               end else begin
                  offset_d = dir ? (offset_q - 4'd1) : (offset_q + 4'd1);
                  state_d  = S_WRITE;
                  wr_d     = 1'b1;
                  sel_d    = 3'd0;
                  num_d    = buf_q[offset_d];
               end
            end else begin
               tick_d = tick_q - TICK_LAST;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         wr_q         <= 1'b0;
         sel_q        <= 3'd0;
         num_q        <= 4'd0;
         frame_done_q <= 1'b0;
         offset_q     <= 4'd0;
         tick_q       <= '0;
         pend_q       <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            buf_q[i] <= 4'd0;
         end
      end else begin
         state_q      <= state_d;
         wr_q         <= wr_d;
         sel_q        <= sel_d;
         num_q        <= num_d;
         frame_done_q <= frame_done_d;
         offset_q     <= offset_d;
         tick_q       <= tick_d;
         pend_q       <= pend_d;
         for (int i = 0; i < 16; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

   assign wr         = wr_q;
   assign sel        = sel_q;
   assign num        = num_q;
   assign frame_done = frame_done_q;
   assign offset     = offset_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Randomized self-checking bench for seg_scroll_ctrl against a frame-level model
// (message array, window offset arithmetic, frame period of 8+TICK_DIV cycles).
module tb_seg_scroll_ctrl;
   localparam int TD = 4;
   localparam int CW = 4;

   logic       CLK = 1'b0;
   logic       rst;
   logic       load_en;
   logic [3:0] load_addr;
   logic [3:0] load_data;
   logic       start;
   logic       stop;
   logic       dir;
   logic       wr;
   logic [2:0] sel;
   logic [3:0] num;
   logic       busy;
   logic       frame_done;
   logic [3:0] offset;

   int         errors = 0;
   int         checks = 0;
   logic [3:0] mem [16];
   int         model_off;

   seg_scroll_ctrl #(.TICK_DIV(TD), .CW(CW)) dut (
      .CLK(CLK), .rst(rst),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .start(start), .stop(stop), .dir(dir),
      .wr(wr), .sel(sel), .num(num), .busy(busy),
      .frame_done(frame_done), .offset(offset)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic load(input logic [3:0] a, input logic [3:0] d);
      @(negedge CLK);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge CLK);
      load_en   = 1'b0;
      mem[a]    = d;
   endtask

   task automatic start_scroll();
      @(negedge CLK);
      start = 1'b1;
      stop  = 1'b0;
      @(negedge CLK);
      start = 1'b0;
   endtask

   // Entered at the negedge where digit 0 of the frame should be visible; returns one
   // full frame period later, where the next frame (or idle) should be visible.
   task automatic run_frame(input int off, input bit d, input int stop_at, input int inj_at,
                            input logic [3:0] inj_addr, input logic [3:0] inj_data,
                            output int next_off);
      logic [3:0] exp_num;
      logic [3:0] last_num;
      logic       exp_fd;
      bit         stopping;
      bit         upd;
      stopping = 1'b0;
      upd      = 1'b0;
      last_num = 4'd0;
      dir      = d;
      for (int n = 0; n <= 7 + TD; n++) begin
         checks++;
         if (n < 8) begin
            exp_num = mem[(off + n) % 16];
            if (wr !== 1'b1 || sel !== 3'(n) || num !== exp_num || offset !== 4'(off) ||
                busy !== 1'b1 || frame_done !== 1'b0) begin
               errors++;
               $display("FAIL digit%0d off=%0d: got wr=%b sel=%0d num=%h offset=%0d busy=%b fd=%b, required wr=1 sel=%0d num=%h offset=%0d busy=1 fd=0",
                        n, off, wr, sel, num, offset, busy, frame_done, n, exp_num, off);
            end
            last_num = exp_num;
         end else begin
            exp_fd = (n == 8);
            if (wr !== 1'b0 || sel !== 3'd7 || num !== last_num || offset !== 4'(off) ||
                busy !== 1'b1 || frame_done !== exp_fd) begin
               errors++;
               $display("FAIL wait%0d off=%0d: got wr=%b sel=%0d num=%h offset=%0d busy=%b fd=%b, required wr=0 sel=7 num=%h offset=%0d busy=1 fd=%b",
                        n, off, wr, sel, num, offset, busy, frame_done, last_num, off, exp_fd);
            end
         end
         if (upd) begin
            mem[inj_addr] = inj_data;
            load_en       = 1'b0;
            upd           = 1'b0;
         end
         stop = 1'b0;
         if (n == stop_at) begin
            stop     = 1'b1;
            stopping = 1'b1;
         end
         if (n == inj_at) begin
            load_en   = 1'b1;
            load_addr = inj_addr;
            load_data = inj_data;
            upd       = 1'b1;
         end
         @(negedge CLK);
      end
      if (upd) begin
         mem[inj_addr] = inj_data;
         load_en       = 1'b0;
      end
      stop = 1'b0;
      checks++;
      if (stopping) begin
         next_off = off;
         if (wr !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || offset !== 4'(off)) begin
            errors++;
            $display("FAIL stop_end off=%0d: got wr=%b busy=%b fd=%b offset=%0d, required wr=0 busy=0 fd=0 offset=%0d",
                     off, wr, busy, frame_done, offset, off);
         end
      end else begin
         next_off = d ? (off + 15) % 16 : (off + 1) % 16;
         if (wr !== 1'b1 || sel !== 3'd0 || offset !== 4'(next_off)) begin
            errors++;
            $display("FAIL next_frame dir=%0d: got wr=%b sel=%0d offset=%0d, required wr=1 sel=0 offset=%0d",
                     d, wr, sel, offset, next_off);
         end
      end
   endtask

   task automatic check_idle(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(negedge CLK);
         checks++;
         if (wr !== 1'b0 || busy !== 1'b0 || offset !== 4'(model_off)) begin
            errors++;
            $display("FAIL %s cycle%0d: got wr=%b busy=%b offset=%0d, required wr=0 busy=0 offset=%0d",
                     tag, i, wr, busy, offset, model_off);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      checks++;
      if (wr !== 1'b0 || sel !== 3'd0 || num !== 4'd0 || busy !== 1'b0 ||
          frame_done !== 1'b0 || offset !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: got wr=%b sel=%0d num=%h busy=%b fd=%b offset=%0d, required all 0",
                  wr, sel, num, busy, frame_done, offset);
      end
      @(negedge CLK);
      @(negedge CLK);
      rst = 1'b1;
      check_idle(20, "idle_after_reset");
   endtask

   task automatic test_single_frame();
      int nxt;
      for (int i = 0; i < 16; i++) load(4'(i), 4'(i));
      start_scroll();
      run_frame(model_off, 1'b0, -1, -1, 4'd0, 4'd0, nxt);
      model_off = nxt;
      run_frame(model_off, 1'b0, -1, -1, 4'd0, 4'd0, nxt);
      model_off = nxt;
   endtask

   task automatic test_wrap_left();
      int nxt;
      while (model_off != 0) begin
         run_frame(model_off, 1'b0, -1, -1, 4'd0, 4'd0, nxt);
         model_off = nxt;
      end
   endtask

   task automatic test_wrap_right();
      int nxt;
      run_frame(model_off, 1'b1, -1, -1, 4'd0, 4'd0, nxt);
      model_off = nxt;
   endtask

   task automatic test_stop();
      int nxt;
      run_frame(model_off, 1'b0, 3, -1, 4'd0, 4'd0, nxt);
      model_off = nxt;
      check_idle(6, "idle_after_stop");
      @(negedge CLK);
      stop = 1'b1;
      check_idle(3, "stop_alone_idle");
      stop  = 1'b0;
      start = 1'b1;
      stop  = 1'b1;
      check_idle(1, "start_and_stop_idle");
      start = 1'b0;
      stop  = 1'b0;
      check_idle(12, "no_frame_after_start_stop");
   endtask

   task automatic test_load_during_scroll();
      int         nxt;
      logic [3:0] a;
      logic [3:0] d;
      a = 4'((model_off + 2) % 16);
      d = ~mem[a];
      start_scroll();
      run_frame(model_off, 1'b0, -1, 1, a, d, nxt);
      model_off = nxt;
      run_frame(model_off, 1'b0, 5, -1, 4'd0, 4'd0, nxt);
      model_off = nxt;
   endtask

   task automatic test_random();
      int nxt;
      int nframes;
      int ia;
      for (int i = 0; i < 16; i++) load(4'(i), 4'($urandom_range(15, 0)));
      start_scroll();
      nframes = $urandom_range(12, 6);
      for (int f = 0; f < nframes; f++) begin
         ia = int'($urandom_range(7 + TD, 0)) - 1;
         run_frame(model_off, 1'($urandom_range(1, 0)),
                   (f == nframes - 1) ? int'($urandom_range(6 + TD, 0)) : -1,
                   ia, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), nxt);
         model_off = nxt;
      end
      check_idle(3, "idle_after_random");
   endtask

   task automatic test_reset_midframe();
      int nxt;
      start_scroll();
      repeat (3) @(negedge CLK);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (wr !== 1'b0 || sel !== 3'd0 || num !== 4'd0 || busy !== 1'b0 ||
          frame_done !== 1'b0 || offset !== 4'd0) begin
         errors++;
         $display("FAIL reset_midframe: got wr=%b sel=%0d num=%h busy=%b fd=%b offset=%0d, required all 0",
                  wr, sel, num, busy, frame_done, offset);
      end
      for (int i = 0; i < 16; i++) mem[i] = 4'd0;
      model_off = 0;
      @(negedge CLK);
      rst = 1'b1;
      check_idle(2, "idle_after_midframe_reset");
      start_scroll();
      run_frame(model_off, 1'b0, 2, -1, 4'd0, 4'd0, nxt);
      model_off = nxt;
   endtask

   initial begin
      load_en   = 1'b0;
      load_addr = 4'd0;
      load_data = 4'd0;
      start     = 1'b0;
      stop      = 1'b0;
      dir       = 1'b0;
      model_off = 0;
      for (int i = 0; i < 16; i++) mem[i] = 4'd0;
      test_reset();
      test_single_frame();
      test_wrap_left();
      test_wrap_right();
      test_stop();
      test_load_during_scroll();
      test_random();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
